// File: rtl/pmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// pmem_responder_pkg
//   Shared types for the physical-memory responder:
//     cache_line        - 128-bit line moved on the pmem interface
//     lc3b_word         - 16-bit byte address
//     lc3b_mem_wmask    - 2-bit byte-enable (carried but ignored)
//     pmem_resp_state_t - responder FSM state (IDLE, BUSY, RESP), 2 bits
//   Also holds address-split constants and a saturating-increment helper.
// ----------------------------------------------------------------------------
package pmem_responder_pkg;

  typedef logic [127:0] cache_line;
  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } pmem_resp_state_t;

  // Byte-offset bits inside a 16-byte line, and the remaining line-address bits.
  localparam int LINE_OFFSET_BITS = 4;
  localparam int LINE_ADDR_BITS   = 16 - LINE_OFFSET_BITS;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pmem_responder_line_array.sv
// ----------------------------------------------------------------------------
// pmem_line_array
//   2^INDEX_BITS x 128-bit line storage with one synchronous write port and
//   one synchronous read port. The read register is only updated when i_re
//   is high, so o_rdata holds its value between reads; it is cleared by rst.
//   The storage array itself is never cleared.
//   Ports:
//     clk      - clock
//     rst      - synchronous active-high reset (read register only)
//     i_we     - write enable
//     i_waddr  - write line index
//     i_wdata  - write line
//     i_re     - read enable
//     i_raddr  - read line index
//     o_rdata  - registered read line
// ----------------------------------------------------------------------------
module pmem_line_array
  import pmem_responder_pkg::*;
#(
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_waddr,
  input  cache_line             i_wdata,
  input  logic                  i_re,
  input  logic [INDEX_BITS-1:0] i_raddr,
  output cache_line             o_rdata
);

  localparam int DEPTH = 1 << INDEX_BITS;

  cache_line r_mem [DEPTH];
  cache_line r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pmem_responder.sv
// ----------------------------------------------------------------------------
// pmem_responder
//   Line-granular main-memory responder for the pmem interface. Accepts one
//   read or write at a time and pulses pmem_resp exactly LATENCY cycles after
//   acceptance. Keeps saturating completion counters and a sticky
//   protocol-error flag.
//   Ports:
//     clk, rst          - clock, synchronous active-high reset
//     pmem_read/write   - request levels, held until pmem_resp
//     pmem_address      - byte address, [3:0] ignored
//     pmem_wdata        - write line
//     pmem_byte_enable  - ignored (writes are full-line)
//     pmem_resp         - one-cycle completion pulse
//     pmem_rdata        - registered read line
//     read_count        - completed reads (saturating)
//     write_count       - completed writes (saturating)
//     proto_error       - sticky protocol-violation flag
// ----------------------------------------------------------------------------
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pmem_read,
  input  logic          pmem_write,
  input  lc3b_word      pmem_address,
  input  cache_line     pmem_wdata,
  input  lc3b_mem_wmask pmem_byte_enable,
  output logic          pmem_resp,
  output cache_line     pmem_rdata,
  output logic [15:0]   read_count,
  output logic [15:0]   write_count,
  output logic          proto_error
);

  localparam logic [7:0] LAT_M1  = 8'(LATENCY - 1);
  localparam bit         LAT_ONE = (LATENCY == 1);

  pmem_resp_state_t          r_state;
  logic [7:0]                r_cnt;
  logic                      r_is_write;
  logic [LINE_ADDR_BITS-1:0] r_addr_hi;
  cache_line                 r_wdata;
  logic                      r_resp;
  logic [15:0]               r_read_count;
  logic [15:0]               r_write_count;
  logic                      r_proto_error;

  logic [LINE_ADDR_BITS-1:0] w_addr_hi;
  logic [INDEX_BITS-1:0]     w_req_index;
  logic [INDEX_BITS-1:0]     w_lat_index;
  logic                      w_req;
  logic                      w_cmd_mismatch;
  logic                      w_addr_mismatch;
  logic                      w_re;
  logic                      w_we;
  logic [INDEX_BITS-1:0]     w_raddr;
  logic                      w_unused_ok;

  assign w_addr_hi   = pmem_address[15:LINE_OFFSET_BITS];
  assign w_req_index = pmem_address[LINE_OFFSET_BITS +: INDEX_BITS];
  assign w_lat_index = r_addr_hi[INDEX_BITS-1:0];
  assign w_req       = pmem_read | pmem_write;

  // Byte enables and the in-line offset carry no meaning for full-line access.
  assign w_unused_ok = &{1'b0, pmem_byte_enable, pmem_address[LINE_OFFSET_BITS-1:0]};

  // The held command must stay exactly the latched one (write-only or read-only).
  assign w_cmd_mismatch  = r_is_write ? (!pmem_write || pmem_read)
                                      : (!pmem_read  || pmem_write);
  assign w_addr_mismatch = (w_addr_hi != r_addr_hi);

  // Storage read is issued one cycle before RESP so the data lands with
  // pmem_resp. With LATENCY==1 that cycle is the acceptance cycle itself,
  // so the index comes straight from the bus.
  assign w_re = (LAT_ONE && (r_state == S_IDLE) && pmem_read && !pmem_write) ||
                ((r_state == S_BUSY) && (r_cnt == 8'd1) && !r_is_write);
  assign w_raddr = (r_state == S_IDLE) ? w_req_index : w_lat_index;

  // Commit on the edge that ends RESP; a reset on that edge aborts the write.
  assign w_we = (r_state == S_RESP) && r_is_write && !rst;

  pmem_line_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_line_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_lat_index),
    .i_wdata (r_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (pmem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_is_write    <= 1'b0;
      r_addr_hi     <= '0;
      r_wdata       <= '0;
      r_resp        <= 1'b0;
      r_read_count  <= '0;
      r_write_count <= '0;
      r_proto_error <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // Write wins when both are requested.
            r_is_write <= pmem_write;
            r_addr_hi  <= w_addr_hi;
            r_wdata    <= pmem_wdata;
            r_cnt      <= LAT_M1;
            if (pmem_read && pmem_write) begin
              r_proto_error <= 1'b1;
            end
            if (LAT_ONE) begin
              r_state <= S_RESP;
              r_resp  <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (w_cmd_mismatch || w_addr_mismatch) begin
            r_proto_error <= 1'b1;
          end
          r_cnt <= r_cnt - 8'd1;
          // Counter was loaded with LATENCY-1; leaving at 1 lands RESP
          // exactly LATENCY cycles after acceptance.
          if (r_cnt == 8'd1) begin
            r_state <= S_RESP;
            r_resp  <= 1'b1;
          end
        end
        S_RESP: begin
          if (w_cmd_mismatch || w_addr_mismatch) begin
            r_proto_error <= 1'b1;
          end
          if (r_is_write) begin
            r_write_count <= sat_inc16(r_write_count);
          end else begin
            r_read_count <= sat_inc16(r_read_count);
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pmem_resp   = r_resp;
  assign read_count  = r_read_count;
  assign write_count = r_write_count;
  assign proto_error = r_proto_error;

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Line-granular physical-memory responder that sits at the far end of the pmem interface driven by the L2 cache and eviction write buffer. It accepts one read or write request at a time and answers with a single-cycle `pmem_resp` after a fixed, parameterised latency. It serves as the synthesizable main-memory model for top-level simulation and for the FPGA build. It also keeps saturating request counters and a sticky protocol-error flag for verification.

## Interface
- `LATENCY`, 10 — cycles from request acceptance to `pmem_resp`; legal range 1..255.
- `INDEX_BITS`, 8 — number of line-index bits; storage holds 2^INDEX_BITS 128-bit lines.
- `clk` in 1 — the single clock; everything is on the rising edge.
- `rst` in 1 — synchronous reset, active-high.
- `pmem_read` in 1 — read request level; held by the initiator until `pmem_resp`.
- `pmem_write` in 1 — write request level; held by the initiator until `pmem_resp`.
- `pmem_address` in 16 (`lc3b_word`) — byte address; bits [3:0] are ignored.
- `pmem_wdata` in 128 (`cache_line`) — write line.
- `pmem_byte_enable` in 2 (`lc3b_mem_wmask`) — accepted and ignored; writes are always full-line.
- `pmem_resp` out 1 — one-cycle completion pulse.
- `pmem_rdata` out 128 (`cache_line`) — read line; registered.
- `read_count` out 16 — completed reads; saturates at 16'hFFFF.
- `write_count` out 16 — completed writes; saturates at 16'hFFFF.
- `proto_error` out 1 — sticky protocol-violation flag.

## Operation
- **Line index:** `pmem_address[4+INDEX_BITS-1:4]`. Higher address bits alias modulo depth and are not an error.
- **FSM states:** IDLE, BUSY, RESP. The state type is 2 bits.
- **IDLE:**
  - If `pmem_read` or `pmem_write` is high, latch the command, index and `pmem_wdata`, and load the down-counter with `LATENCY-1`.
  - Go to RESP if `LATENCY==1`, otherwise to BUSY.
- **BUSY:** decrement the counter. Go to RESP on the cycle the counter reaches 1 → 0 transition boundary, so that RESP is entered exactly `LATENCY` cycles after acceptance.
- **RESP:**
  - `pmem_resp` = 1 for this one cycle.
  - A latched write commits the latched line to storage at the end of this cycle.
  - A latched read drives `pmem_rdata` from storage during this cycle.
  - The matching counter increments. Next state is IDLE.
- **Simultaneous read and write at acceptance:** the write wins, the read is dropped, and `proto_error` is set.
- **While BUSY or RESP:**
  - If the command deasserts, or `pmem_address[15:4]` or the command type differs from the latched values, set `proto_error`.
  - The transaction still completes using the latched values.
- **Back-to-back requests:** a request present in the IDLE cycle directly after RESP is accepted. There is no dead cycle.
- **Read-after-write:** a read of a line returns the most recently committed write to that line.
- **`pmem_rdata`:** holds its last value outside RESP cycles. Its value is 0 after reset until the first read.
- **Storage:**
  - Not cleared by `rst`.
  - Zero-initialised at simulation start.
  - An optional preload via `$readmemh` is a simulation-only hook and not part of this spec.

## Timing
- **Reset values:** `pmem_resp`=0, `pmem_rdata`=0, `read_count`=0, `write_count`=0, `proto_error`=0, state=IDLE.
- **Reset mid-transaction:** the transaction is aborted, no `pmem_resp` is issued, a pending write is not committed, and the counters clear.
- **Acceptance cycle t:** the cycle in which the request is first high while IDLE. `pmem_resp` is high in cycle t+LATENCY only.
- **Read data:** valid in the same cycle as `pmem_resp`. The storage read is synchronous, with its address taken from the latched index one cycle before RESP, i.e. in the last BUSY cycle or in the acceptance cycle when `LATENCY==1`.
- **Write commit:** on the rising edge that ends the RESP cycle. A read accepted in the following cycle therefore sees the new data.
- **Throughput:** one transaction per `LATENCY`+1 cycles under a continuous request stream.

## Structure
- Add `pmem_resp_state_t` (IDLE, BUSY, RESP) to the shared `cache_types` package. `cache_line`, `lc3b_word` and `lc3b_mem_wmask` come from the existing packages.
- One sub-module, `pmem_line_array`:
  - 2^INDEX_BITS × 128 storage.
  - One synchronous write port and one synchronous read port.
  - Write-before-read is not required because of the commit/accept ordering above.
- The FSM, latency counter, request latches, counters and error logic live in `pmem_responder`.

## Test plan
- **Reset values:** hold `rst` for 2 cycles, then idle → all outputs 0 and no `pmem_resp` for 20 cycles.
- **Write then read, LATENCY=10:**
  - Write 128'hDEAD…BEEF to address 16'h1230 → `pmem_resp` exactly 10 cycles after acceptance and `write_count`=1.
  - Read of 16'h123C → `pmem_rdata`=128'hDEAD…BEEF with resp at +10 and `read_count`=1.
- **Back-to-back, LATENCY=1:** a read is issued immediately after a write resp to the same line → the new data is returned, with resp pulses 2 cycles apart.
- **Simultaneous read and write:** both high with address 16'h0040 → treated as a write, `proto_error`=1, `read_count` unchanged.
- **Mid-transaction violation:** the address changes from 16'h0100 to 16'h0200 during BUSY → data is committed to line 16'h0100 and `proto_error`=1.
- **Reset mid-write:** assert `rst` 3 cycles into a write to 16'h0500 → no resp, and a later read of 16'h0500 returns the prior contents (0).
